// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the combinational ALU and the multiply/divide unit.
package alu_pkg;
    typedef enum logic [2:0] {
        OP_AND  = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_ZERO = 3'b011,
        OP_ANDN = 3'b100, OP_ORN = 3'b101, OP_SUB = 3'b110, OP_SLT  = 3'b111
    } alu_ctrl_t;
    typedef enum logic [2:0] {
        MDOP_NOP  = 3'b000, MDOP_MULT = 3'b001, MDOP_MULTU = 3'b010, MDOP_DIV  = 3'b011,
        MDOP_DIVU = 3'b100, MDOP_MTHI = 3'b101, MDOP_MTLO  = 3'b110, MDOP_RSVD = 3'b111
    } md_op_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam md_op_t MD_NOP = MDOP_NOP;
endpackage

// File: rtl/md_core.sv
// md_core: iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// Next-state values are exported so the final step can be written to HI/LO on the same edge.
module md_core #(parameter int N = 32) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         div_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] acc_nx_o,
    output logic [N-1:0] q_nx_o,
    output logic         last_o
);
    localparam int CW = $clog2(N + 1);
    logic [N-1:0]  acc_q, q_q, m_q;
    logic [CW-1:0] cnt_q;
    logic          div_q;
    logic [N:0]    sum, rem, diff;
    always_comb begin
        sum      = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
        rem      = {acc_q, q_q[N-1]};
        diff     = rem - {1'b0, m_q};
        acc_nx_o = div_q ? (diff[N] ? rem[N-1:0] : diff[N-1:0]) : sum[N:1];
        q_nx_o   = div_q ? {q_q[N-2:0], ~diff[N]} : {sum[0], q_q[N-1:1]};
        last_o   = cnt_q == CW'(1);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            q_q   <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= '0;
            q_q   <= a_i;
            m_q   <= b_i;
            div_q <= div_i;
            cnt_q <= CW'(N);
        end else if (step_i) begin
            acc_q <= acc_nx_o;
            q_q   <= q_nx_o;
            cnt_q <= cnt_q - CW'(1);
        end
    end
endmodule

// File: rtl/alu_md.sv
// alu_md: combinational MIPS ALU plus an iterative multiply/divide unit with HI/LO registers.
// Signed MD ops run on magnitudes; signs are re-applied when the result is written.
module alu_md
    import alu_pkg::*;
#(parameter int N = 32) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] src1,
    input  logic [N-1:0] src2,
    input  logic [2:0]   alu_ctrl_sig,
    output logic [N-1:0] alu_out,
    output logic         zero,
    output logic         overflow,
    input  logic [2:0]   md_op,
    input  logic         md_start,
    output logic         md_busy,
    output logic         md_done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    md_state_t    state_q;
    md_op_t       op;
    alu_ctrl_t    ctrl;
    logic [N-1:0] sum, diff, a_mag, b_mag, acc_nx, q_nx, hi_q, lo_q, hi_d, lo_d;
    logic [2*N-1:0] prod;
    logic ovf_add, ovf_sub, is_md, sgn, dv, load, last;
    logic busy_q, done_q, div_q, neg_q, rneg_q, div0_q;
    always_comb begin
        ctrl    = alu_ctrl_t'(alu_ctrl_sig);
        sum     = src1 + src2;
        diff    = src1 - src2;
        ovf_add = (src1[N-1] == src2[N-1]) && (sum[N-1] != src1[N-1]);
        ovf_sub = (src1[N-1] != src2[N-1]) && (diff[N-1] != src1[N-1]);
        case (ctrl)
            OP_AND:  alu_out = src1 & src2;
            OP_OR:   alu_out = src1 | src2;
            OP_ADD:  alu_out = sum;
            OP_ANDN: alu_out = src1 & ~src2;
            OP_ORN:  alu_out = src1 | ~src2;
            OP_SUB:  alu_out = diff;
            OP_SLT:  alu_out = {{(N-1){1'b0}}, diff[N-1] ^ ovf_sub};
            default: alu_out = '0;
        endcase
        zero     = alu_out == '0;
        overflow = ctrl == OP_ADD ? ovf_add : (ctrl == OP_SUB || ctrl == ALU_SLT) ? ovf_sub : 1'b0;
    end
    always_comb begin
        op    = md_op_t'(md_op);
        is_md = op inside {MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU};
        sgn   = op == MDOP_MULT || op == MDOP_DIV;
        dv    = op == MDOP_DIV || op == MDOP_DIVU;
        load  = state_q == IDLE && md_start && is_md;
        a_mag = (sgn && src1[N-1]) ? -src1 : src1;
        b_mag = (sgn && src2[N-1]) ? -src2 : src2;
        prod  = neg_q ? -{acc_nx, q_nx} : {acc_nx, q_nx};
        hi_d  = div_q ? (rneg_q ? -acc_nx : acc_nx) : prod[2*N-1:N];
        lo_d  = div_q ? (div0_q ? '1 : neg_q ? -q_nx : q_nx) : prod[N-1:0];
    end
    md_core #(.N(N)) u_core (
        .clk_i(clk), .rst_ni(reset_n), .load_i(load), .step_i(state_q == RUN), .div_i(dv),
        .a_i(a_mag), .b_i(b_mag), .acc_nx_o(acc_nx), .q_nx_o(q_nx), .last_o(last)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            {hi_q, lo_q} <= '0;
            {busy_q, done_q, div_q, neg_q, rneg_q, div0_q} <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        div_q   <= dv;
                        neg_q   <= sgn && (src1[N-1] ^ src2[N-1]);
                        rneg_q  <= sgn && src1[N-1];
                        div0_q  <= dv && src2 == '0;
                    end else if (md_start && op == MDOP_MTHI) hi_q <= src1;
                    else if (md_start && op == MDOP_MTLO) lo_q <= src1;
                end
                RUN: if (last) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
    assign md_busy = busy_q;
    assign md_done = done_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed ALU vectors plus a scoreboard-checked multiply/divide sequence.
module tb_alu_md;
    logic        clk = 0, reset_n = 0, md_start = 0, zero, overflow, md_busy, md_done;
    logic [31:0] src1 = 0, src2 = 0, alu_out, hi, lo;
    logic [2:0]  alu_ctrl_sig = 0, md_op = 0;
    logic [63:0] sb[$];
    int total = 0, bad = 0, busy_run = 0;
    logic prev_busy = 0;

    alu_md #(.N(32)) dut (
        .clk(clk), .reset_n(reset_n), .src1(src1), .src2(src2), .alu_ctrl_sig(alu_ctrl_sig),
        .alu_out(alu_out), .zero(zero), .overflow(overflow), .md_op(md_op), .md_start(md_start),
        .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals completion.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset_n) begin
            busy_run = 0;
            prev_busy = 0;
        end else begin
            if (md_done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL md_done_unexpected: got=done expected=no done");
                end else begin
                    e = sb.pop_front();
                    chk("md_hi", hi, e[63:32]);
                    chk("md_lo", lo, e[31:0]);
                end
                chk("busy_cycles", busy_run, 32);
                chk("done_follows_busy", prev_busy, 1);
                chk("busy_in_done", md_busy, 0);
                busy_run = 0;
            end
            if (md_busy) busy_run++;
            prev_busy = md_busy;
        end
    end

    task automatic alu(input logic [2:0] c, input logic [31:0] a, b, r, input logic ov, z);
        alu_ctrl_sig = c;
        src1 = a;
        src2 = b;
        #1;
        chk($sformatf("alu_out c=%0d", c), alu_out, r);
        chk($sformatf("alu_ovf c=%0d", c), overflow, ov);
        chk($sformatf("alu_zero c=%0d", c), zero, z);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!md_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!md_done) begin
            total++;
            bad++;
            $display("FAIL md_done_timeout: got=no done expected=done within 100 cycles");
        end
    endtask

    task automatic md_run(input logic [2:0] op, input logic [31:0] a, b, input logic [63:0] exp);
        @(negedge clk);
        md_op = op;
        src1 = a;
        src2 = b;
        md_start = 1;
        sb.push_back(exp);
        @(negedge clk);
        md_start = 0;
        md_op = 0;
        chk("busy_after_start", md_busy, 1);
        wait_done();
    endtask

    task automatic pulse(input logic [2:0] op, input logic [31:0] a);
        md_op = op;
        src1 = a;
        md_start = 1;
        @(negedge clk);
        md_start = 0;
        md_op = 0;
    endtask

    initial begin
        #3;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", md_busy, 0);
        chk("rst_done", md_done, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        alu(3'b111, 32'h80000000, 32'h1, 32'h1, 1, 0);
        alu(3'b110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0);
        alu(3'b010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
        alu(3'b010, 32'h5, 32'hFFFFFFFB, 32'h0, 0, 1);
        alu(3'b000, 32'hF0F0, 32'hFF00, 32'hF000, 0, 0);
        alu(3'b001, 32'h1, 32'h2, 32'h3, 0, 0);
        alu(3'b100, 32'hF0F0, 32'hFF00, 32'h00F0, 0, 0);
        alu(3'b101, 32'h0, 32'hFFFFFFFE, 32'h1, 0, 0);
        alu(3'b011, 32'h123, 32'h456, 32'h0, 0, 1);
        alu(3'b111, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0);
        alu(3'b111, 32'h5, 32'h3, 32'h0, 0, 1);
        alu(3'b110, 32'h3, 32'h3, 32'h0, 0, 1);
        md_run(3'b001, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
        md_run(3'b010, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE);
        md_run(3'b001, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        md_run(3'b100, 32'd100, 32'd7, 64'h00000002_0000000E);
        md_run(3'b011, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        md_run(3'b011, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        md_run(3'b100, 32'd5, 32'd0, 64'h00000005_FFFFFFFF);
        md_run(3'b011, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF);
        md_run(3'b011, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        // Requests during RUN and DONE must be dropped.
        @(negedge clk);
        md_op = 3'b001;
        src1 = 3;
        src2 = 4;
        md_start = 1;
        sb.push_back(64'h00000000_0000000C);
        @(negedge clk);
        md_start = 0;
        repeat (3) @(negedge clk);
        pulse(3'b101, 32'hDEAD);
        src2 = 7;
        pulse(3'b001, 32'd7);
        chk("hi_untouched_in_run", hi, 0);
        wait_done();
        pulse(3'b101, 32'hBEEF);
        chk("mthi_in_done_ignored", hi, 0);
        pulse(3'b101, 32'hDEAD);
        chk("mthi_after_done", hi, 32'hDEAD);
        chk("md_busy_after_mthi", md_busy, 0);
        pulse(3'b110, 32'h1234);
        chk("mtlo", lo, 32'h1234);
        chk("mthi_kept", hi, 32'hDEAD);
        pulse(3'b111, 32'h5555);
        chk("rsvd_no_effect", lo, 32'h1234);
        // Asynchronous reset between edges aborts a running divide.
        @(negedge clk);
        md_op = 3'b100;
        src1 = 32'hFFFF;
        src2 = 3;
        md_start = 1;
        @(negedge clk);
        md_start = 0;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("arst_busy", md_busy, 0);
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        md_run(3'b100, 32'd1000, 32'd10, 64'h00000000_00000064);
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Next-generation datapath ALU for the single-cycle/multi-cycle MIPS cores.
- Keeps the combinational 3-bit-controlled ALU path, with width parametrised throughout, a correct signed set-less-than and a signed overflow flag.
- Adds an iterative multiply/divide unit with architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO) and a start/busy/done handshake toward the controller.

Parameters:
- N, 32, datapath width in bits; must be ≥ 4 and even.
- CW, $clog2(N+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- src1  in  N  operand A (rs).
- src2  in  N  operand B (rt).
- alu_ctrl_sig  in  3  combinational ALU operation select.
- alu_out  out  N  combinational ALU result.
- zero  out  1  alu_out == 0.
- overflow  out  1  signed overflow of ADD (010) or SUB/SLT (110/111); 0 for other ops.
- md_op  in  3  multiply/divide operation, md_op_t.
- md_start  in  1  single-cycle request pulse, sampled in IDLE only.
- md_busy  out  1  high while an iteration is in progress.
- md_done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
- hi  out  N  HI register (MFHI source).
- lo  out  N  LO register (MFLO source).

Behaviour:
- Reset (async assert, sync release): state=IDLE, hi=lo=0, md_busy=0, md_done=0, counter=0. Reset mid-operation aborts the operation; HI/LO read 0 afterwards.
- ALU path is purely combinational and independent of the MD state machine.
  - 000 AND, 001 OR, 010 ADD, 011 result 0, 100 A&~B, 101 A|~B, 110 SUB.
  - 111 SLT = {(N-1)'0, sub_msb ^ sub_ovf}, so it is correct across overflow.
  - overflow = operand signs equal (ADD) or differ (SUB) and result sign differs from A.
- MD encoding (md_op_t): 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP).
- State machine: IDLE → RUN → DONE → IDLE.
- IDLE:
  - md_start with MULT/MULTU/DIV/DIVU:
    - Latch operands. Signed ops latch magnitudes plus result sign bits: quotient/product sign = sA^sB, remainder sign = sA.
    - counter=N, enter RUN.
  - md_start with MTHI/MTLO: hi (resp. lo) ← src1 at that edge; stay IDLE; no md_done.
  - NOP/reserved: no effect.
- RUN:
  - md_busy=1. One iteration per cycle: shift-add for multiply; restoring shift-subtract for divide, one quotient bit per cycle. counter decrements.
  - On the cycle counter reaches 1, the next edge applies sign correction, writes {hi,lo}, and enters DONE.
- DONE:
  - md_busy=0, md_done=1 for exactly one cycle, then IDLE.
  - md_start is ignored in DONE; the earliest accepted restart is the cycle after DONE.
- Latency: start sampled at edge t → md_busy high in cycles t+1..t+N → md_done high in cycle t+N+1.
- md_start while in RUN/DONE, any op including MTHI/MTLO, is ignored. HI/LO are not modified until the DONE write.
- Results:
  - Multiply: {hi,lo} = full 2N-bit product.
  - Divide: lo = quotient, hi = remainder. Signed division truncates toward zero; remainder takes the dividend's sign.
  - Divide by zero (src2==0): completes with normal latency; lo = all ones, hi = src1.
  - DIV of most-negative by -1: lo = most-negative, hi = 0; no trap.

Decomposition:
- Package alu_pkg holds:
  - alu_ctrl_t enum (3-bit codes above);
  - md_op_t enum;
  - md_state_t enum {IDLE, RUN, DONE};
  - constants ALU_SLT=3'b111 and MD_NOP.
- Sub-module md_core #(N) is the iterative datapath: accumulator/remainder and quotient/multiplier shift registers plus the counter, driven by load/step strobes.
- alu_md keeps the combinational ALU, the FSM, sign handling and the HI/LO registers.

Test Plan:
- ALU, N=32: src1=0x80000000, src2=1, ctrl=111 → alu_out=1, overflow=1. Same operands with ctrl=110 → alu_out=0x7FFFFFFF, zero=0.
- MULT -3×5: start at t → busy t+1..t+32, done at t+33, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 → lo=0xFFFFFFFD, hi=1.
- DIVU 5/0 → after 32 busy cycles: lo=0xFFFFFFFF, hi=5.
- MULT 3×4 started; MTHI(0xDEAD) and a second MULT pulsed during RUN → both ignored; done after 32 busy cycles with hi=0, lo=12; MTHI accepted in the cycle after done.
- Reset asserted asynchronously mid-RUN (between edges) → busy=0 immediately, hi=lo=0; a new DIVU after release completes normally.
